pwm_width_meter: RTL and testbench

- Receive-side counterpart of the sine-driven PWM width generator. It measures an incoming PWM waveform and reports pulse width and period in clk cycles.
- Used to close the loop in the sine-PWM project: the generator's PWM output, or an external PWM line, is demodulated back into width samples. Those samples are compared against the sine ROM table.
- Includes an input synchronizer, edge detection, a 4-state FSM, measurement counters, and a timeout for 0%/100% duty.

---
 rtl/pwm_width_meter.sv | 149 ++++++++++++++
 tb/tb_pwm_width_meter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_width_meter.sv
// Measures an incoming PWM waveform: high time and rising-edge-to-rising-edge period in clk cycles,
// with a sticky timeout flag for inputs stuck at 0% or 100% duty.
module pwm_width_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] width_out,
  output logic [WIDTH-1:0] period_out,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

  logic             sync1_r, pwm_s_r, pwm_d_r;
  logic [1:0]       prime_r;
  logic             rise_s, fall_s;
  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_hi_r, cnt_hi_s, cnt_per_r, cnt_per_s;
  logic [WIDTH-1:0] width_r, width_s, period_r, period_s;
  logic             valid_r, valid_s, timeout_r, timeout_s;

  assign rise_s = pwm_s_r & ~pwm_d_r;
  assign fall_s = ~pwm_s_r & pwm_d_r;

  // Two-flop synchronizer, edge-detect flop, and a fill marker so IDLE ignores the reset value of pwm_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      pwm_s_r <= 1'b0;
      pwm_d_r <= 1'b0;
      prime_r <= 2'b00;
    end else begin
      sync1_r <= pwm_in;
      pwm_s_r <= sync1_r;
      pwm_d_r <= pwm_s_r;
      prime_r <= {prime_r[0], 1'b1};
    end
  end

  // Next-state, counter and report logic; a rise in LOW beats a simultaneous timeout.
  always_comb begin
    state_s   = state_r;
    cnt_hi_s  = cnt_hi_r;
    cnt_per_s = cnt_per_r;
    width_s   = width_r;
    period_s  = period_r;
    valid_s   = 1'b0;
    timeout_s = timeout_r;
    if (!en) begin
      state_s   = IDLE;
      cnt_hi_s  = ZERO_C;
      cnt_per_s = ZERO_C;
      timeout_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (prime_r[1] && !pwm_s_r) begin
            state_s = ARM;
          end else begin
            state_s = IDLE;
          end
        end
        ARM: begin
          if (rise_s) begin
            cnt_hi_s  = ONE_C;
            cnt_per_s = ONE_C;
            state_s   = HIGH;
          end else begin
            state_s = ARM;
          end
        end
        HIGH: begin
          if (cnt_per_r == TIMEOUT_C) begin
            state_s   = IDLE;
            timeout_s = 1'b1;
          end else if (fall_s) begin
            cnt_per_s = cnt_per_r + ONE_C;
            state_s   = LOW;
          end else begin
            cnt_hi_s  = cnt_hi_r + ONE_C;
            cnt_per_s = cnt_per_r + ONE_C;
          end
        end
        LOW: begin
          if (rise_s) begin
            width_s   = cnt_hi_r;
            period_s  = cnt_per_r;
            valid_s   = 1'b1;
            timeout_s = 1'b0;
            cnt_hi_s  = ONE_C;
            cnt_per_s = ONE_C;
            state_s   = HIGH;
          end else if (cnt_per_r == TIMEOUT_C) begin
            state_s   = IDLE;
            timeout_s = 1'b1;
          end else begin
            cnt_per_s = cnt_per_r + ONE_C;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_hi_r  <= ZERO_C;
      cnt_per_r <= ZERO_C;
      width_r   <= ZERO_C;
      period_r  <= ZERO_C;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_hi_r  <= cnt_hi_s;
      cnt_per_r <= cnt_per_s;
      width_r   <= width_s;
      period_r  <= period_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
    end
  end

  assign width_out  = width_r;
  assign period_out = period_r;
  assign valid      = valid_r;
  assign timeout    = timeout_r;
  assign level      = pwm_s_r;

endmodule

// File: tb/tb_pwm_width_meter.sv
// Directed and random PWM streams against a timestamp-based reference model of the width meter.
module tb_pwm_width_meter;

  localparam int W  = 32;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst_n, en, pwm_in;
  logic [W-1:0] width_out, period_out;
  logic         valid, timeout, level;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  // Reference model: synchronizer delay line plus edge timestamps.
  bit           m_p1, m_s, m_d;
  bit           m_need_low, m_meas, m_fallen;
  int           m_t, m_t_rise, m_t_fall, m_edges;
  logic [W-1:0] e_width, e_period;
  bit           e_valid, e_to, e_level;

  always #5 clk = ~clk;

  pwm_width_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pwm_in     (pwm_in),
    .width_out  (width_out),
    .period_out (period_out),
    .valid      (valid),
    .timeout    (timeout),
    .level      (level)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = 1'b0; m_s = 1'b0; m_d = 1'b0;
    m_need_low = 1'b1; m_meas = 1'b0; m_fallen = 1'b0;
    m_t_rise = 0; m_t_fall = 0; m_edges = 0;
    e_width = '0; e_period = '0; e_valid = 1'b0; e_to = 1'b0; e_level = 1'b0;
  endtask

  task automatic model_step();
    bit r, f;
    r = m_s & ~m_d;
    f = ~m_s & m_d;
    e_valid = 1'b0;
    if (!en) begin
      m_need_low = 1'b1;
      m_meas     = 1'b0;
      e_to       = 1'b0;
    end else if (m_meas) begin
      if (m_fallen && r) begin
        e_width  = W'(m_t_fall - m_t_rise);
        e_period = W'(m_t - m_t_rise);
        e_valid  = 1'b1;
        e_to     = 1'b0;
        m_t_rise = m_t;
        m_fallen = 1'b0;
      end else if (m_t - m_t_rise == TO) begin
        m_meas     = 1'b0;
        m_need_low = 1'b1;
        e_to       = 1'b1;
      end else if (!m_fallen && f) begin
        m_fallen = 1'b1;
        m_t_fall = m_t;
      end
    end else if (m_need_low) begin
      if (m_edges >= 2 && !m_s) m_need_low = 1'b0;
    end else if (r) begin
      m_meas   = 1'b1;
      m_t_rise = m_t;
      m_fallen = 1'b0;
    end
    m_d = m_s;
    m_s = m_p1;
    m_p1 = pwm_in;
    e_level = m_s;
    m_t++;
    m_edges++;
  endtask

  task automatic check_all(input string where);
    chk({where, ".valid"},   W'(valid),   W'(e_valid));
    chk({where, ".width"},   width_out,   e_width);
    chk({where, ".period"},  period_out,  e_period);
    chk({where, ".timeout"}, W'(timeout), W'(e_to));
    chk({where, ".level"},   W'(level),   W'(e_level));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all("cyc");
    if (valid === 1'b1) n_valid++;
  endtask

  task automatic drive(input int hi, input int lo, input int reps);
    for (int k = 0; k < reps; k++) begin
      for (int i = 0; i < hi; i++) begin pwm_in = 1'b1; tick(); end
      for (int i = 0; i < lo; i++) begin pwm_in = 1'b0; tick(); end
    end
  endtask

  initial begin
    m_t = 0;
    rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1; en = 1'b1;

    // 3 high / 5 low
    drive(3, 5, 6);
    n_valid = 0;
    drive(3, 5, 3);
    chk("w35", width_out, W'(3));
    chk("p35", period_out, W'(8));
    chk("v35_count", W'(n_valid), W'(3));

    // switch to 6 high / 2 low
    drive(6, 2, 5);
    chk("w62", width_out, W'(6));
    chk("p62", period_out, W'(8));

    // stuck high -> timeout, then recover
    for (int i = 0; i < 4; i++) begin pwm_in = 1'b1; tick(); end
    n_valid = 0;
    for (int i = 0; i < 36; i++) begin pwm_in = 1'b1; tick(); end
    chk("to_set", W'(timeout), W'(1));
    chk("to_novalid", W'(n_valid), W'(0));
    drive(3, 5, 4);
    chk("to_clr", W'(timeout), W'(0));
    chk("to_w", width_out, W'(3));
    chk("to_p", period_out, W'(8));

    // asynchronous reset in the middle of a high phase
    drive(3, 5, 2);
    pwm_in = 1'b1; tick(); tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin pwm_in = 1'b1; tick(); end
    drive(3, 5, 4);
    chk("rst_w", width_out, W'(3));
    chk("rst_p", period_out, W'(8));

    // drop enable in a low phase
    drive(6, 2, 2);
    drive(3, 5, 2);
    pwm_in = 1'b1; tick(); tick(); tick();
    pwm_in = 1'b0; tick(); tick(); tick(); tick();
    en = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin pwm_in = (i >= 2 && i < 5); tick(); end
    chk("en_novalid", W'(n_valid), W'(0));
    chk("en_hold_w", width_out, W'(3));
    chk("en_hold_p", period_out, W'(8));
    en = 1'b1;
    drive(3, 5, 4);
    chk("en_w", width_out, W'(3));
    chk("en_p", period_out, W'(8));

    // period exactly TIMEOUT: rise wins
    drive(10, 10, 3);
    chk("bnd_p", period_out, W'(20));
    chk("bnd_to", W'(timeout), W'(0));

    // minimum waveform 1/1
    drive(1, 1, 8);
    n_valid = 0;
    drive(1, 1, 5);
    chk("w11", width_out, W'(1));
    chk("p11", period_out, W'(2));
    chk("v11_count", W'(n_valid), W'(5));

    // random duty
    for (int k = 0; k < 1000; k++) begin
      drive(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
